// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared constants for the forwarding/hazard scoreboard: forwarding-select encoding,
// result latencies and named stage indices, plus the latency clamp used at issue.
package pipe_hazard_scoreboard_pkg;

  localparam int FWD_REGFILE = 0;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  localparam int STG_EXE = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // A latency of 0 means "ALU"; nothing can take longer than reaching WB.
  function automatic int clamp_lat(input int lat, input int depth);
    if (lat < LAT_ALU) return LAT_ALU;
    if (lat > depth)   return depth;
    return lat;
  endfunction

endpackage

// File: rtl/hazard_port_lookup.sv
// Priority search of the in-flight write slots for one ID-stage read port.
// Returns the forwarding select and whether the operand is ready this cycle.
module hazard_port_lookup
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int SW    = 2
) (
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  input  logic [DEPTH-1:0]    slot_v,
  input  logic [DEPTH-1:0]    slot_wen,
  input  logic [DEPTH-1:0]    slot_busy,
  input  logic [DEPTH*AW-1:0] slot_waddr,
  output logic                ready,
  output logic [SW-1:0]       sel
);

  // NOTE: combinational blocks use blocking '=' with defaults assigned first, so
  // every path drives every output and no latch is inferred.
  always_comb begin
    ready = 1'b1;
    sel   = SW'(FWD_REGFILE);
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rd_en && (rd_addr != '0) && slot_v[i] && slot_wen[i] &&
          (slot_waddr[i*AW +: AW] == rd_addr)) begin
        sel   = SW'(i + 1);
        ready = !slot_busy[i];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Forwarding and hazard unit: tracks in-flight register writes through the post-ID
// stages and produces per-port forwarding selects plus a single stall request.
module pipe_hazard_scoreboard
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int LATW  = 2,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [AW-1:0]     issue_waddr,
  input  logic [LATW-1:0]   issue_lat,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*SW-1:0] fwd_sel,
  output logic              stall,
  output logic              issue_fire,
  output logic [31:0]       stall_cnt
);

  logic [DEPTH-1:0]  v_q, v_d, wen_q, wen_d;
  logic [AW-1:0]     waddr_q [DEPTH];
  logic [AW-1:0]     waddr_d [DEPTH];
  logic [LATW-1:0]   rem_q   [DEPTH];
  logic [LATW-1:0]   rem_d   [DEPTH];
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]    slot_busy;
  logic [DEPTH*AW-1:0] slot_waddr;
  logic [NRD-1:0]      port_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_busy[i]              = (rem_q[i] != '0);
      slot_waddr[i*AW +: AW]    = waddr_q[i];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    hazard_port_lookup #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .SW    (SW)
    ) u_lookup (
      .rd_en      (rd_en[p]),
      .rd_addr    (rd_addr[p*AW +: AW]),
      .slot_v     (v_q),
      .slot_wen   (wen_q),
      .slot_busy  (slot_busy),
      .slot_waddr (slot_waddr),
      .ready      (port_ready[p]),
      .sel        (fwd_sel[p*SW +: SW])
    );
  end

  // Flush squashes the ID instruction, so it cannot be waiting on anything.
  assign stall      = issue_valid && !flush && !(&port_ready);
  assign issue_fire = issue_valid && !stall && !flush && !hold;
  assign stall_cnt  = stall_cnt_q;

  always_comb begin
    v_d         = v_q;
    wen_d       = wen_q;
    waddr_d     = waddr_q;
    rem_d       = rem_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        v_d[i]     = v_q[i-1];
        wen_d[i]   = wen_q[i-1];
        waddr_d[i] = waddr_q[i-1];
        rem_d[i]   = (rem_q[i-1] != '0) ? rem_q[i-1] - 1'b1 : '0;
      end
      v_d[STG_EXE]     = issue_fire;
      wen_d[STG_EXE]   = issue_fire && issue_wen;
      waddr_d[STG_EXE] = issue_fire ? issue_waddr : '0;
      rem_d[STG_EXE]   = issue_fire ?
                         LATW'(clamp_lat(int'(issue_lat), DEPTH) - 1) : '0;
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // NOTE: the slot array is a handful of flops rather than a RAM, so every field
  // is cleared by the asynchronous reset instead of relying on v alone.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      v_q         <= '0;
      wen_q       <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      v_q         <= v_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench: directed hazard scenarios then random traffic, compared against
// an age/latency model of in-flight writes kept as a queue of issued instructions.
module tb_pipe_hazard_scoreboard;
  import pipe_hazard_scoreboard_pkg::*;

  localparam int NRD   = 2;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int LATW  = 2;
  localparam int SW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              cpu_rst_n = 1'b0;
  logic              hold = 1'b0, flush = 1'b0;
  logic              issue_valid = 1'b0, issue_wen = 1'b0;
  logic [AW-1:0]     issue_waddr = '0;
  logic [LATW-1:0]   issue_lat = '0;
  logic [NRD-1:0]    rd_en = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*SW-1:0] fwd_sel;
  logic              stall, issue_fire;
  logic [31:0]       stall_cnt;

  pipe_hazard_scoreboard #(
    .NRD (NRD), .DEPTH (DEPTH), .AW (AW), .LATW (LATW)
  ) dut (
    .clk         (clk),
    .cpu_rst_n   (cpu_rst_n),
    .hold        (hold),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_waddr (issue_waddr),
    .issue_lat   (issue_lat),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each issued writer remembers when it entered EXE (in advancing
  // cycles) and its effective latency; its age gives the stage it sits in.
  typedef struct {
    logic [AW-1:0] waddr;
    int            stamp;
    int            lat;
  } rec_t;

  rec_t inflight[$];
  int   adv = 0;
  int   m_cnt = 0;

  function automatic void model_port(input logic en, input logic [AW-1:0] addr,
                                     output int sel, output bit not_ready);
    sel = 0;
    not_ready = 1'b0;
    if (!en || addr == 0) return;
    foreach (inflight[k]) begin
      if (inflight[k].waddr == addr) begin
        sel = adv - inflight[k].stamp;          // age + 1
        not_ready = adv < inflight[k].stamp + inflight[k].lat;
        return;
      end
    end
  endfunction

  task automatic step(input bit v, input bit wen, input int waddr, input int lat,
                      input logic [1:0] en, input int a0, input int a1,
                      input bit h = 1'b0, input bit fl = 1'b0);
    int  sel [NRD];
    bit  nr  [NRD];
    bit  exp_stall, exp_fire;
    issue_valid = v;
    issue_wen   = wen;
    issue_waddr = AW'(waddr);
    issue_lat   = LATW'(lat);
    rd_en       = en;
    rd_addr     = {AW'(a1), AW'(a0)};
    hold        = h;
    flush       = fl;
    #1;
    model_port(en[0], AW'(a0), sel[0], nr[0]);
    model_port(en[1], AW'(a1), sel[1], nr[1]);
    exp_stall = v && !fl && (nr[0] || nr[1]);
    exp_fire  = v && !exp_stall && !fl && !h;
    check("stall", 32'(stall), 32'(exp_stall));
    check("issue_fire", 32'(issue_fire), 32'(exp_fire));
    check("fwd_sel0", 32'(fwd_sel[0 +: SW]), 32'(sel[0]));
    check("fwd_sel1", 32'(fwd_sel[SW +: SW]), 32'(sel[1]));
    check("stall_cnt", stall_cnt, 32'(m_cnt));
    @(posedge clk);
    if (!h) begin
      if (exp_stall) m_cnt++;
      if (exp_fire && wen)
        inflight.push_front('{waddr: AW'(waddr), stamp: adv,
                              lat: clamp_lat(lat, DEPTH)});
      adv++;
      while (inflight.size() > 0 && adv - inflight[$].stamp - 1 >= DEPTH)
        void'(inflight.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_fire", 32'(issue_fire), 0);
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_cnt", stall_cnt, 0);
    @(negedge clk);
    cpu_rst_n = 1'b1;

    // ALU back-to-back: $3 forwarded from EXE, then MEM, then WB.
    step(1, 1, 3, LAT_ALU, 2'b00, 0, 0);
    step(1, 1, 4, LAT_ALU, 2'b11, 3, 3);
    step(1, 0, 0, LAT_ALU, 2'b01, 3, 0);
    step(1, 0, 0, LAT_ALU, 2'b01, 3, 0);
    idle(3);

    // Load-use: one stall, then $5 from MEM, $1 from the regfile.
    step(1, 1, 5, LAT_LOAD, 2'b00, 0, 0);
    step(1, 1, 6, LAT_ALU, 2'b11, 5, 1);
    step(1, 1, 6, LAT_ALU, 2'b11, 5, 1);
    idle(3);

    // Younger ALU write to $7 shadows the older load.
    step(1, 1, 7, LAT_LOAD, 2'b00, 0, 0);
    step(1, 1, 7, LAT_ALU, 2'b00, 0, 0);
    step(1, 0, 0, LAT_ALU, 2'b11, 7, 7);
    idle(3);

    // $0 never forwards; a disabled port never stalls.
    step(1, 1, 9, LAT_LOAD, 2'b00, 0, 0);
    step(1, 1, 0, LAT_LOAD, 2'b00, 0, 0);
    step(1, 0, 0, LAT_ALU, 2'b01, 0, 9);
    idle(3);

    // hold freezes a pending stall, then flush overrides it.
    step(1, 1, 10, LAT_LOAD, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, LAT_ALU, 2'b01, 10, 0, 1'b1, 1'b0);
    step(1, 0, 0, LAT_ALU, 2'b01, 10, 0, 1'b0, 1'b1);
    step(1, 0, 0, LAT_ALU, 2'b01, 10, 0);
    idle(3);

    // Asynchronous reset between edges with a load in flight.
    step(1, 1, 12, LAT_LOAD, 2'b00, 0, 0);
    issue_valid = 1'b1; issue_wen = 1'b0; rd_en = 2'b01; rd_addr = {AW'(0), AW'(12)};
    #1;
    check("pre_rst_stall", 32'(stall), 1);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    check("async_rst_stall", 32'(stall), 0);
    check("async_rst_fwd", 32'(fwd_sel), 0);
    check("async_rst_cnt", stall_cnt, 0);
    inflight.delete();
    m_cnt = 0;
    @(negedge clk);
    cpu_rst_n = 1'b1;
    issue_valid = 1'b0;
    rd_en = '0;
    idle(1);

    // Random traffic with a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9, 0) < 8, $urandom_range(1, 0), $urandom_range(7, 0),
           $urandom_range(3, 0), 2'($urandom_range(3, 0)),
           $urandom_range(7, 0), $urandom_range(7, 0),
           $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
